// File: rtl/mult_job_sequencer.sv
// Job sequencer for the shift-add multiplier. It buffers operand pairs in a FIFO
// and launches one job at a time. Each result is returned on a valid/ready stream with its tag.
module mult_job_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mul_start,
    output logic [31:0] mul_opa,
    output logic [31:0] mul_opb,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod,
    output logic [3:0]  out_tag,
    output logic        out_err,
    output logic        busy,
    output logic [15:0] jobs_done
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]    r_state;
    logic [35:0]   r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_tag_ctr;
    logic [3:0]    r_job_tag;
    logic [15:0]   r_wd;
    logic [31:0]   r_opa;
    logic [31:0]   r_opb;
    logic          r_out_valid;
    logic [31:0]   r_out_prod;
    logic [3:0]    r_out_tag;
    logic          r_out_err;
    logic [15:0]   r_jobs_done;

    logic [35:0] w_head;
    logic [15:0] w_head_a;
    logic [15:0] w_head_b;
    logic [3:0]  w_head_tag;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_take;
    logic        w_bypass;
    logic        w_done_ok;
    logic        w_tmo;
    logic        w_load;

    assign w_head     = r_fifo[r_rd_ptr];
    assign w_head_a   = w_head[35:20];
    assign w_head_b   = w_head[19:4];
    assign w_head_tag = w_head[3:0];
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = in_valid && in_ready;
    // A job leaves the FIFO only when its result is sure to have a free output slot.
    assign w_take     = (r_state == S_IDLE) && !w_empty && (!r_out_valid || out_ready);
    assign w_bypass   = w_take && ((w_head_a == '0) || (w_head_b == '0));
    assign w_done_ok  = (r_state == S_WAIT) && mul_done;
    assign w_tmo      = (r_state == S_WAIT) && !mul_done && (r_wd == WD_LAST);
    assign w_load     = w_bypass || w_done_ok || w_tmo;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {in_a, in_b, r_tag_ctr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tag_ctr   <= '0;
            r_job_tag   <= '0;
            r_wd        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_out_valid <= 1'b0;
            r_out_prod  <= '0;
            r_out_tag   <= '0;
            r_out_err   <= 1'b0;
            r_jobs_done <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr  <= r_wr_ptr + AW'(1);
                r_tag_ctr <= r_tag_ctr + 4'd1;
            end
            if (w_take) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_take) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (!w_push && w_take) begin
                r_count <= r_count - (AW+1)'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_take && !w_bypass) begin
                        r_opa     <= {16'd0, w_head_a};
                        r_opb     <= {16'd0, w_head_b};
                        r_job_tag <= w_head_tag;
                        r_state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_wd    <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_wd <= r_wd + 16'd1;
                    if (mul_done || w_tmo) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_prod  <= w_done_ok ? mul_result : '0;
                r_out_tag   <= w_bypass ? w_head_tag : r_job_tag;
                r_out_err   <= w_tmo;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_out_valid && out_ready) begin
                r_jobs_done <= r_jobs_done + 16'd1;
            end
        end
    end

    assign in_ready  = rst && !w_full;
    assign mul_start = (r_state == S_LAUNCH);
    assign mul_opa   = r_opa;
    assign mul_opb   = r_opb;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_prod  = r_out_prod;
    assign out_tag   = r_out_tag;
    assign out_err   = r_out_err;
    assign jobs_done = r_jobs_done;
endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural multiplier of programmable latency.
// All signals are sampled and driven on the falling clock edge.
module tb_mult_job_sequencer;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        mul_start;
    logic [31:0] mul_opa;
    logic [31:0] mul_opb;
    logic        mul_done;
    logic [31:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_prod;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;
    logic [15:0] jobs_done;

    mult_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_start(mul_start), .mul_opa(mul_opa), .mul_opb(mul_opb),
        .mul_done(mul_done), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
        .out_tag(out_tag), .out_err(out_err), .busy(busy), .jobs_done(jobs_done)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Multiplier model: m_lat = cycles from mul_start to mul_done, 0 means never answer.
    int m_lat    = 0;
    int m_starts = 0;
    bit inj_done = 1'b0;
    initial begin : mul_model
        int cnt;
        bit act;
        logic [31:0] ma;
        logic [31:0] mb;
        cnt = 0; act = 1'b0; ma = '0; mb = '0;
        mul_done = 1'b0; mul_result = '0;
        forever begin
            @(negedge clk);
            mul_done = 1'b0;
            if (act) begin
                if (cnt > 1) cnt--;
                else begin
                    mul_done   = 1'b1;
                    mul_result = ma * mb;
                    act        = 1'b0;
                end
            end
            if (inj_done) begin
                mul_done = 1'b1;
                inj_done = 1'b0;
            end
            if (mul_start) begin
                m_starts++;
                if (m_lat > 0) begin
                    act = 1'b1; cnt = m_lat; ma = mul_opa; mb = mul_opb;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int k;
        in_a = a; in_b = b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("push accepted", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int t);
        int k;
        k = 0;
        while (!mul_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!mul_start) chk("mul_start seen", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic wait_valid(output int t);
        int k;
        k = 0;
        while (!out_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) chk("out_valid seen", 32'd0, 32'd1);
        t = cyc;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin : stim
        int s;
        int e;
        int acc;
        int idx;
        int st0;
        bit ok;
        logic [15:0] pa [6];
        logic [15:0] pb [6];
        logic [31:0] ep [5];
        pa = '{16'd2, 16'd7,  16'd100, 16'hFFFF, 16'd1234, 16'd4};
        pb = '{16'd3, 16'd11, 16'd200, 16'hFFFF, 16'd5,    16'd4};
        ep = '{32'd6, 32'd77, 32'd20000, 32'hFFFE_0001, 32'd6170};

        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 1'b0);
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst mul_start", mul_start, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst out_prod", out_prod, 32'd0);
        chk("rst jobs_done", jobs_done, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-rst in_ready", in_ready, 1'b1);

        // Single job 3*5, multiplier answers 10 cycles after the start pulse.
        m_lat = 10; st0 = m_starts;
        push(16'd3, 16'd5);
        wait_start(s);
        chk("t1 mul_opa", mul_opa, 32'd3);
        chk("t1 mul_opb", mul_opb, 32'd5);
        chk("t1 busy", busy, 1'b1);
        @(negedge clk);
        chk("t1 start one cycle", mul_start, 1'b0);
        ok = 1'b1;
        for (int k = 0; k < 100 && !out_valid; k++) begin
            if (mul_opa !== 32'd3 || mul_opb !== 32'd5) ok = 1'b0;
            @(negedge clk);
        end
        e = cyc;
        chk("t1 operands held", ok, 1'b1);
        chk("t1 latency", e - s, 32'd11);
        chk("t1 out_prod", out_prod, 32'd15);
        chk("t1 out_tag", out_tag, 4'd0);
        chk("t1 out_err", out_err, 1'b0);
        @(negedge clk);
        chk("t1 jobs_done", jobs_done, 16'd1);
        chk("t1 valid drops", out_valid, 1'b0);
        chk("t1 start count", m_starts - st0, 32'd1);

        // Zero-operand bypass, back-to-back pushes.
        do_reset();
        st0 = m_starts;
        in_a = 16'd0; in_b = 16'd7; in_valid = 1'b1;
        chk("t2 in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_a = 16'd9; in_b = 16'd0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2 r0 valid", out_valid, 1'b1);
        chk("t2 r0 tag", out_tag, 4'd0);
        chk("t2 r0 prod", out_prod, 32'd0);
        chk("t2 r0 err", out_err, 1'b0);
        @(negedge clk);
        chk("t2 r1 valid", out_valid, 1'b1);
        chk("t2 r1 tag", out_tag, 4'd1);
        chk("t2 r1 prod", out_prod, 32'd0);
        @(negedge clk);
        chk("t2 valid drops", out_valid, 1'b0);
        chk("t2 jobs_done", jobs_done, 16'd2);
        chk("t2 no start", m_starts - st0, 32'd0);

        // Backpressure: output stalled, FIFO fills after 5 accepted pairs.
        do_reset();
        m_lat = 3; out_ready = 1'b0; acc = 0;
        for (int k = 0; k < 20; k++) begin
            if (acc < 6) begin
                in_a = pa[acc]; in_b = pb[acc]; in_valid = 1'b1;
                if (in_ready) acc++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t3 accepted", acc, 32'd5);
        chk("t3 in_ready full", in_ready, 1'b0);
        chk("t3 held valid", out_valid, 1'b1);
        chk("t3 held tag", out_tag, 4'd0);
        chk("t3 held prod", out_prod, 32'd6);
        chk("t3 jobs_done", jobs_done, 16'd0);
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || out_tag !== 4'd0 || out_prod !== 32'd6 || in_ready) ok = 1'b0;
        end
        chk("t3 stable under stall", ok, 1'b1);
        out_ready = 1'b1; idx = 0;
        for (int k = 0; k < 300 && idx < 5; k++) begin
            if (out_valid) begin
                chk("t3 tag order", out_tag, idx[3:0]);
                chk("t3 prod", out_prod, ep[idx]);
                chk("t3 err", out_err, 1'b0);
                idx++;
            end
            @(negedge clk);
        end
        chk("t3 delivered", idx, 32'd5);
        chk("t3 jobs_done", jobs_done, 16'd5);

        // Timeout: no answer; decision 255 cycles after the start, visible one cycle later.
        do_reset();
        m_lat = 0;
        push(16'd6, 16'd7);
        wait_start(s);
        @(negedge clk);
        chk("t4 busy", busy, 1'b1);
        wait_valid(e);
        chk("t4 timeout latency", e - s, 32'd256);
        chk("t4 err", out_err, 1'b1);
        chk("t4 prod", out_prod, 32'd0);
        chk("t4 tag", out_tag, 4'd0);
        @(negedge clk);
        chk("t4 idle after", busy, 1'b0);
        inj_done = 1'b1;
        repeat (3) @(negedge clk);
        chk("t4 late done ignored", out_valid, 1'b0);
        chk("t4 jobs_done", jobs_done, 16'd1);
        m_lat = 4;
        push(16'd8, 16'd9);
        wait_start(s);
        wait_valid(e);
        chk("t4 next latency", e - s, 32'd5);
        chk("t4 next prod", out_prod, 32'd72);
        chk("t4 next err", out_err, 1'b0);
        chk("t4 next tag", out_tag, 4'd1);
        @(negedge clk);

        // Done arrives in the same cycle the watchdog expires: done wins.
        m_lat = 255;
        push(16'd10, 16'd20);
        wait_start(s);
        wait_valid(e);
        chk("t5 tie latency", e - s, 32'd256);
        chk("t5 tie err", out_err, 1'b0);
        chk("t5 tie prod", out_prod, 32'd200);
        chk("t5 tie tag", out_tag, 4'd2);
        @(negedge clk);

        // Reset while waiting for the multiplier.
        m_lat = 50;
        push(16'd3, 16'd3);
        wait_start(s);
        repeat (5) @(negedge clk);
        chk("t6 busy in wait", busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6 in_ready", in_ready, 1'b0);
        chk("t6 out_valid", out_valid, 1'b0);
        chk("t6 busy", busy, 1'b0);
        chk("t6 mul_start", mul_start, 1'b0);
        chk("t6 mul_opa", mul_opa, 32'd0);
        chk("t6 mul_opb", mul_opb, 32'd0);
        chk("t6 out_prod", out_prod, 32'd0);
        chk("t6 out_tag", out_tag, 4'd0);
        chk("t6 out_err", out_err, 1'b0);
        chk("t6 jobs_done", jobs_done, 16'd0);
        rst = 1'b1;
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (out_valid || busy) ok = 1'b0;
        end
        chk("t6 stale done ignored", ok, 1'b1);
        chk("t6 in_ready after", in_ready, 1'b1);
        push(16'd0, 16'd0);
        wait_valid(e);
        chk("t6 tag restart", out_tag, 4'd0);
        chk("t6 bypass prod", out_prod, 32'd0);
        @(negedge clk);
        chk("t6 jobs_done", jobs_done, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global time limit: simulation still running at %0t", $time);
        $fatal(1);
    end
endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
Upstream feeder and result collector for the shift-add multiplier datapath. Operand pairs arrive on a valid/ready stream and are buffered in a small FIFO. Each job is launched into the multiplier with a one-cycle start pulse; the block then waits for done, captures the product and presents it on a valid/ready result stream with a tag. Zero operands bypass the multiplier, and a watchdog converts a missing done into an error result.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, >=2)
TIMEOUT, 255, max cycles from mul_start to mul_done before error (>=2, <=2^16-1)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept (= !full)
in_a  in  16  multiplicand
in_b  in  16  multiplier
mul_start  out  1  one-cycle launch pulse to multiplier
mul_opa  out  32  zero-extended multiplicand, held stable from launch until job ends
mul_opb  out  32  zero-extended multiplier, held stable likewise
mul_done  in  1  multiplier completion strobe
mul_result  in  32  product, valid in the mul_done cycle
out_valid  out  1  result valid
out_ready  in  1  result consumer ready
out_prod  out  32  product
out_tag  out  4  job sequence number (mod 16, assigned at FIFO push)
out_err  out  1  result produced by timeout
busy  out  1  job in flight (LAUNCH or WAIT)
jobs_done  out  16  count of results handed off, wraps at 2^16

Behaviour:
- Reset (rst=0 at an edge): FSM->IDLE, FIFO empty, tag counter 0, in_ready=0 during reset then 1, mul_start=0, mul_opa=mul_opb=0, out_valid=0, out_prod=0, out_tag=0, out_err=0, busy=0, jobs_done=0, watchdog=0. Reset mid-job abandons it; a later mul_done is ignored.
- FIFO: push on in_valid&&in_ready with {in_a,in_b,tag}; tag increments on each push. in_ready=0 when full, so there is no push while full. Pop happens only in IDLE on launch/bypass. Push and pop in the same cycle are legal; occupancy is unchanged.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE: a job is taken when FIFO is non-empty and the output slot is free, i.e. out_valid==0 or out_ready==1 this cycle.
    - If the head has a==0 or b==0, it is a bypass: pop, load out_prod=0, out_tag=head tag, out_err=0, out_valid=1 next cycle, and stay in IDLE. Throughput is one bypass per cycle.
    - Otherwise: pop, register mul_opa/mul_opb/job tag, go to LAUNCH.
  - LAUNCH: mul_start=1 for exactly this cycle, busy=1, watchdog cleared to 0; go to WAIT.
  - WAIT: busy=1, watchdog increments every cycle.
    - If mul_done=1: out_prod=mul_result, out_tag=job tag, out_err=0, out_valid=1 next cycle; go to IDLE.
    - Else if watchdog==TIMEOUT-1: out_prod=0, out_err=1, out_valid=1; go to IDLE.
    - If mul_done and timeout coincide, done wins.
- mul_done outside WAIT (IDLE/LAUNCH) is ignored.
- Only one job is in flight. The output slot holds one result; out_prod/out_tag/out_err are stable while out_valid&&!out_ready. out_valid drops after the handshake unless a new result loads in the same cycle.
- jobs_done increments on each out_valid&&out_ready.
- Latency, non-zero job: push at edge t -> mul_start high in cycle t+2 (IDLE pop t+1, LAUNCH t+2) -> mul_done at cycle d -> out_valid high from d+1.
- Latency, bypass: push at t -> out_valid from t+2.
- Products are the low 32 bits of mul_result as delivered; no width checking.

Test Plan:
- Single job: in_a=3, in_b=5, model returns 15 after 10 cycles -> exactly one mul_start pulse, mul_opa=3, mul_opb=5 held until done; out_prod=15, out_tag=0, out_err=0, jobs_done=1.
- Zero bypass: push (0,7) then (9,0) -> no mul_start; two results, out_prod=0, tags 0 and 1, on consecutive cycles with out_ready=1.
- Backpressure/full: DEPTH=4, out_ready=0, push 6 pairs of non-zero operands -> in_ready drops after 5 accepted (4 in FIFO + 1 popped); results retained and stable. Release out_ready -> all 5 delivered in tag order 0..4.
- Timeout: model never asserts done, TIMEOUT=255 -> result with out_err=1, out_prod=0 exactly 255 cycles after mul_start. A late mul_done is ignored and the next job proceeds normally.
- Done/timeout tie: done asserted in the cycle watchdog==TIMEOUT-1 -> out_err=0, out_prod=mul_result.
- Reset mid-WAIT: rst=0 for one edge during WAIT -> all outputs at reset values, FIFO empty. A subsequent mul_done produces no result; the tag restarts at 0.
